// File: rtl/taus88_core.sv
// Combined Tausworthe (Taus88) 32-bit uniform random source.
// One registered word per clock; runtime reseed from a single 32-bit value.
module taus88_core #(
   parameter logic [31:0] S1_INIT = 32'h0000_3039,
   parameter logic [31:0] S2_INIT = 32'h0001_0932,
   parameter logic [31:0] S3_INIT = 32'h0000_0929,
   parameter logic [31:0] MIX2    = 32'h9E37_79B9,
   parameter logic [31:0] MIX3    = 32'h6A09_E667
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] seed,
   input  logic        re_seed,
   output logic [31:0] rnd,
   output logic        rnd_valid
);

   logic [31:0] s1, s2, s3;
   logic [31:0] n1, n2, n3;
   logic [31:0] t1, t2, t3;
   logic [31:0] f1, f2, f3;

   always_comb begin
      n1 = ((s1 & 32'hFFFF_FFFE) << 12) ^ (((s1 << 13) ^ s1) >> 19);
      n2 = ((s2 & 32'hFFFF_FFF8) << 4)  ^ (((s2 << 2)  ^ s2) >> 25);
      n3 = ((s3 & 32'hFFFF_FFF0) << 17) ^ (((s3 << 3)  ^ s3) >> 11);
   end

   // Small component states would collapse to an all-zero recurrence.
   always_comb begin
      t1 = seed;
      t2 = seed ^ MIX2;
      t3 = {seed[15:0], seed[31:16]} ^ MIX3;
      f1 = (t1 < 32'd2)  ? (t1 | 32'h2)  : t1;
      f2 = (t2 < 32'd8)  ? (t2 | 32'h8)  : t2;
      f3 = (t3 < 32'd16) ? (t3 | 32'h10) : t3;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1        <= S1_INIT;
         s2        <= S2_INIT;
         s3        <= S3_INIT;
         rnd       <= 32'h0;
         rnd_valid <= 1'b0;
      end else if (re_seed) begin
         s1        <= f1;
         s2        <= f2;
         s3        <= f3;
         rnd_valid <= 1'b0;
      end else begin
         s1        <= n1;
         s2        <= n2;
         s3        <= n3;
         rnd       <= n1 ^ n2 ^ n3;
         rnd_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_taus88_core.sv
// Scoreboard bench for taus88_core: stimulus pushes model words,
// a monitor pops and compares whenever rnd_valid is high.
module tb_taus88_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] seed;
   logic        re_seed;
   logic [31:0] rnd;
   logic        rnd_valid;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] sb[$];
   logic [31:0] hist[$];

   logic [31:0] m1, m2, m3, m_last;

   always #5 clk = ~clk;

   taus88_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed      (seed),
      .re_seed   (re_seed),
      .rnd       (rnd),
      .rnd_valid (rnd_valid)
   );

   function automatic logic [31:0] tstep(
      input logic [31:0] s, input logic [31:0] mask,
      input int k, input int q, input int sh);
      logic [31:0] a, b;
      a = (s & mask) << k;
      b = ((s << q) ^ s) >> sh;
      return a ^ b;
   endfunction

   function automatic logic [31:0] fix(input logic [31:0] t,
                                       input logic [31:0] lim);
      return (t < lim) ? (t | lim) : t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      m1 = 32'h0000_3039;
      m2 = 32'h0001_0932;
      m3 = 32'h0000_0929;
      m_last = 32'h0;
   endtask

   task automatic model_seed(input logic [31:0] s);
      logic [31:0] sw;
      sw = {s[15:0], s[31:16]};
      m1 = fix(s, 32'd2);
      m2 = fix(s ^ 32'h9E37_79B9, 32'd8);
      m3 = fix(sw ^ 32'h6A09_E667, 32'd16);
   endtask

   task automatic model_step();
      m1 = tstep(m1, 32'hFFFF_FFFE, 12, 13, 19);
      m2 = tstep(m2, 32'hFFFF_FFF8, 4, 2, 25);
      m3 = tstep(m3, 32'hFFFF_FFF0, 17, 3, 11);
      m_last = m1 ^ m2 ^ m3;
   endtask

   always @(posedge clk) begin
      #1;
      if (rnd_valid === 1'b1) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_word got=%h exp=none", rnd);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            if (rnd !== e) begin
               n_err++;
               $display("FAIL word got=%h exp=%h", rnd, e);
            end
            hist.push_back(rnd);
         end
      end
   end

   task automatic do_step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n   = 1'b1;
         re_seed = 1'b0;
         model_step();
         sb.push_back(m_last);
      end
      @(posedge clk);
      #2;
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reseed(input logic [31:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n   = 1'b1;
         re_seed = 1'b1;
         seed    = s;
         model_seed(s);
         @(posedge clk);
         #2;
         chk("reseed_valid", {31'h0, rnd_valid}, 32'd0);
         chk("reseed_hold", rnd, m_last);
      end
   endtask

   task automatic do_reset(input int n, input logic rs);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n   = 1'b0;
         re_seed = rs;
         seed    = 32'h5555_AAAA;
         model_reset();
         @(posedge clk);
         #2;
         chk("reset_valid", {31'h0, rnd_valid}, 32'd0);
         chk("reset_rnd", rnd, 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic diff;
      rst_n   = 1'b0;
      re_seed = 1'b0;
      seed    = 32'h0;
      model_reset();

      do_reset(2, 1'b0);
      do_step(10);

      do_reseed(32'hDEAD_BEEF, 1);
      do_step(10);
      do_reseed(32'hDEAD_BEEF, 1);
      do_step(10);

      do_reseed(32'hCAFE_BABE, 1);
      do_step(10);
      do_reseed(32'h1234_5678, 1);
      do_step(10);

      do_reseed(32'h0000_0000, 1);
      hist.delete();
      do_step(8);
      diff = 1'b0;
      if (hist.size() >= 8)
         for (int i = 1; i < 8; i++)
            if (hist[i] !== hist[0]) diff = 1'b1;
      chk("nonconst", {31'h0, diff}, 32'd1);
      do_step(3);

      do_reset(1, 1'b0);
      do_step(10);

      do_step(4);
      do_reset(1, 1'b1);
      do_step(10);

      do_reseed(32'h0BAD_F00D, 3);
      do_step(10);
      do_reseed(32'h0BAD_F00D, 1);
      do_step(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
